if_fetch_stage: RTL

//  - Instruction-fetch front end of the rv32i core; sits directly upstream of mainDeco.
//  - Issues word fetches to instruction memory and buffers returned words in a small FIFO.
//  - Presents {inst, pc} to decode through a valid/ready handshake; op_code = inst[6:0] drives mainDeco.op_code.
//  - Accepts branch/jump redirects: flushes the buffer and discards stale in-flight responses.

---
 rtl/rv32i_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/if_fetch_stage.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared definitions for the rv32i core front end.
//   RV_NOP            canonical NOP (addi x0,x0,0), shown on decode when no instruction is valid
//   OPCODE_W          width of the major opcode field inst[6:0]
//   DEFAULT_RESET_PC  default reset vector
//   OP_*              major opcodes decoded by mainDeco
package rv32i_pkg;
    localparam int unsigned OPCODE_W         = 7;
    localparam logic [31:0] RV_NOP           = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'd3;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'd35;
    localparam logic [OPCODE_W-1:0] OP_R      = 7'd51;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'd99;
    localparam logic [OPCODE_W-1:0] OP_I      = 7'd19;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'd111;
    localparam logic [OPCODE_W-1:0] OP_SYS    = 7'd115;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {instruction, pc} records.
//   clk, rst_n     clock, asynchronous active-low reset
//   flush_i        clears the FIFO; overrides push and pop in the same cycle
//   push_i         write push_data_i at the tail
//   pop_i          remove the head (ignored when empty)
//   head_data_o    current head entry (combinational read)
//   count_o        number of valid entries
// Simultaneous push and pop is legal at any occupancy, including full.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_eff;
    logic             push_eff;

    assign pop_eff     = pop_i && (count_q != '0) && !flush_i;
    assign push_eff    = push_i && !flush_i;
    assign head_data_o = mem_q[rd_ptr_q];
    assign count_o     = count_q;

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_eff) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_eff)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_eff, pop_eff})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // The upstream credit scheme must never push into a full FIFO without a pop.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_eff && !pop_eff && (count_q == CNT_W'(DEPTH))));
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end of the rv32i core, feeding mainDeco.
//   clk, rst_n                       clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_addr  word fetch request channel
//   imem_rsp_valid, imem_rsp_data    in-order fetch responses (latency >= 1)
//   redirect_valid, redirect_pc      taken branch/jump from execute
//   inst_valid/ready, inst_data,
//   inst_pc, op_code                 head of the instruction buffer toward decode
//   misalign_err                     one-cycle pulse after a redirect with pc[1:0] != 0
module if_fetch_stage
    import rv32i_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEFAULT_RESET_PC),
    parameter int unsigned     FIFO_DEPTH = 2,
    parameter int unsigned     MAX_OUT    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [31:0]         imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [31:0]         inst_data,
    output logic [XLEN-1:0]     inst_pc,
    output logic [OPCODE_W-1:0] op_code,
    output logic                misalign_err
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FW    = 32 + XLEN;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             misalign_q, misalign_d;

    logic [CNT_W-1:0] fifo_count;
    logic [FW-1:0]    fifo_head;
    logic [CNT_W:0]   credit_sum;
    logic             req_fire;
    logic             fifo_push;
    logic             fifo_pop;

    // Credit check counts both in-flight requests and buffered entries, so
    // every response is guaranteed a slot. Depends only on registered state
    // and redirect_valid, never on inst_ready or the response channel.
    assign credit_sum     = {1'b0, out_q} + {1'b0, fifo_count};
    assign imem_req_valid = rst_n && !redirect_valid
                            && (out_q < CNT_W'(MAX_OUT))
                            && (credit_sum < (CNT_W + 1)'(FIFO_DEPTH));
    assign imem_addr      = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign fifo_push = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign fifo_pop  = inst_valid && inst_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        misalign_d = 1'b0;
        out_d      = out_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        if (imem_rsp_valid) begin
            if (drop_q != '0) drop_d = drop_q - CNT_W'(1);
            else              rsp_pc_d = rsp_pc_q + XLEN'(4);
        end

        // Redirect wins: everything still in flight after this cycle is stale.
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            rsp_pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
            drop_d     = out_d;
            misalign_d = (redirect_pc[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_valid),
        .push_i      (fifo_push),
        .push_data_i ({imem_rsp_data, rsp_pc_q}),
        .pop_i       (fifo_pop),
        .head_data_o (fifo_head),
        .count_o     (fifo_count)
    );

    assign inst_valid   = (fifo_count != '0);
    assign inst_data    = inst_valid ? fifo_head[FW-1:XLEN] : RV_NOP;
    assign inst_pc      = inst_valid ? fifo_head[XLEN-1:0] : '0;
    assign op_code      = inst_data[OPCODE_W-1:0];
    assign misalign_err = misalign_q;
endmodule
